// File: rtl/prog_loader.sv
// Boot loader: byte stream -> 32-bit instruction-memory writes, then CPU release.
// Optional trailing checksum byte with PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        load_enable,
    output logic [31:0] load_address,
    output logic [31:0] load_data,
    output logic        cpu_reset,
    output logic        fetch_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [16:0] LP_MAX   = 17'(MAX_WORDS);
    localparam logic [31:0] LP_TO    = 32'(TIMEOUT_CYCLES);
    localparam bit          LP_TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_len_lo;
    logic [15:0] r_count;
    logic [23:0] r_word;
    logic [15:0] r_words_loaded;
    logic [31:0] r_idle;
    logic        r_load_enable;
    logic [31:0] r_load_address;
    logic [31:0] r_load_data;
    logic        r_run_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic [15:0] w_n;
    logic        w_n_bad;
    logic        w_busy;
    logic        w_timeout;
    logic        w_last_word;

    assign w_n         = {rx_data, r_len_lo};
    assign w_n_bad     = (w_n == 16'd0) || ({1'b0, w_n} > LP_MAX);
    assign w_last_word = (r_words_loaded + 16'd1) == r_count;
    assign w_timeout   = LP_TO_EN && !rx_valid && (r_idle == LP_TO - 32'd1);

    always_comb begin
        w_busy = 1'b0;
        unique case (r_state)
            S_LEN, S_DATA: w_busy = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM:        w_busy = 1'b1;
`endif
            default:       w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_LEN;
            S_LEN: begin
                if (rx_valid && r_byte_cnt[0])
                    w_next = w_n_bad ? S_ERROR : S_DATA;
                else if (w_timeout)
                    w_next = S_ERROR;
            end
            S_DATA: begin
                if (rx_valid && r_byte_cnt == 2'd3 && w_last_word)
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_RUN;
`endif
                else if (w_timeout)
                    w_next = S_ERROR;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid)
                    w_next = (rx_data == r_csum) ? S_RUN : S_ERROR;
                else if (w_timeout)
                    w_next = S_ERROR;
            end
`endif
            S_RUN, S_ERROR: if (start) w_next = S_LEN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt     <= 2'd0;
            r_len_lo       <= 8'd0;
            r_count        <= 16'd0;
            r_word         <= 24'd0;
            r_words_loaded <= 16'd0;
            r_idle         <= 32'd0;
            r_load_enable  <= 1'b0;
            r_load_address <= 32'd0;
            r_load_data    <= 32'd0;
            r_run_d        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum         <= 8'd0;
`endif
        end else begin
            r_load_enable <= 1'b0;
            r_run_d       <= (r_state == S_RUN);
            // Idle timer only runs while a stream is expected
            if (w_busy && !rx_valid) r_idle <= r_idle + 32'd1;
            else                     r_idle <= 32'd0;

            unique case (r_state)
                S_LEN: begin
                    if (rx_valid) begin
                        if (!r_byte_cnt[0]) begin
                            r_len_lo   <= rx_data;
                            r_byte_cnt <= 2'd1;
                        end else begin
                            r_count    <= w_n;
                            r_byte_cnt <= 2'd0;
                            if (!w_n_bad) begin
                                r_words_loaded <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                                r_csum         <= 8'd0;
`endif
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum + rx_data;
`endif
                        unique case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= rx_data;
                            2'd1: r_word[15:8]  <= rx_data;
                            2'd2: r_word[23:16] <= rx_data;
                            default: begin
                                r_load_enable  <= 1'b1;
                                r_load_data    <= {rx_data, r_word};
                                r_load_address <= BASE_ADDR
                                    + {14'd0, r_words_loaded, 2'b00};
                                r_words_loaded <= r_words_loaded + 16'd1;
                            end
                        endcase
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CSUM: r_byte_cnt <= 2'd0;
`endif
                default: r_byte_cnt <= 2'd0;
            endcase
        end
    end

    assign busy         = w_busy;
    assign done         = (r_state == S_RUN);
    assign error        = (r_state == S_ERROR);
    assign cpu_reset    = (r_state != S_RUN);
    assign fetch_enable = (r_state == S_RUN) && r_run_d;
    assign load_enable  = r_load_enable;
    assign load_address = r_load_address;
    assign load_data    = r_load_data;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a stream-level reference model.
// Honours PROG_LOADER_CHECKSUM_EN when defined for both bench and DUT.
module tb_prog_loader;

    localparam int          MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        load_enable;
    logic [31:0] load_address;
    logic [31:0] load_data;
    logic        cpu_reset;
    logic        fetch_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] tx_w[$];

    prog_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .load_enable(load_enable),
        .load_address(load_address),
        .load_data(load_data),
        .cpu_reset(cpu_reset),
        .fetch_enable(fetch_enable),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_enable) begin
            got_a.push_back(load_address);
            got_d.push_back(load_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b, input bit st);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = st;
        tick();
        rx_valid = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int gap();
        if ($urandom_range(0, 15) == 0) return 15;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic fill(input int n);
        tx_w.delete();
        for (int i = 0; i < n; i++) tx_w.push_back($urandom);
    endtask

    task automatic do_load(input int n, input bit do_start,
                           input bit mid_start, input bit corrupt);
        int         sum;
        bit         exp_err;
        logic [7:0] bt;
        logic [15:0] n16;
        got_a.delete();
        got_d.delete();
        n16 = 16'(n);
        if (do_start) pulse_start();
        check("busy_len", busy, 1);
        check("cpurst_len", cpu_reset, 1);
        check("fetch_len", fetch_enable, 0);
        send(n16[7:0], 1'b0);
        send(n16[15:8], 1'b0);
        if (n == 0 || n > MAXW) begin
            check("err_len", error, 1);
            check("busy_err", busy, 0);
            idle(1);
            check("nostrobe_len", got_a.size(), 0);
            return;
        end
        sum = 0;
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                idle(gap());
                bt = 8'(tx_w[w] >> (8 * b));
                sum = (sum + int'(bt)) % 256;
                send(bt, mid_start && w == 0 && b == 1);
            end
        end
        exp_err = CSUM_EN && corrupt;
        if (CSUM_EN) send(corrupt ? 8'(sum + 1) : 8'(sum), 1'b0);
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("cpu_reset", cpu_reset, exp_err);
        check("fetch_first", fetch_enable, 0);
        idle(1);
        check("fetch_second", fetch_enable, !exp_err);
        check("nwords", got_a.size(), n);
        check("words_loaded", words_loaded, n);
        for (int i = 0; i < n && i < got_a.size(); i++) begin
            check("addr", got_a[i], BASE + 32'(4 * i));
            check("data", got_d[i], tx_w[i]);
        end
    endtask

    initial begin
        idle(3);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_fetch", fetch_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_le", load_enable, 0);
        check("rst_wl", words_loaded, 0);
        check("rst_addr", load_address, 0);
        reset = 1'b0;
        idle(2);
        check("idle_ignore_rx", busy, 0);

        tx_w.delete();
        tx_w.push_back(32'h0010_0513);
        tx_w.push_back(32'h0020_0593);
        do_load(2, 1'b1, 1'b0, 1'b0);
        if (!CSUM_EN) begin
            send(8'hAA, 1'b0);
            check("run_trailing", done, 1);
        end

        do_load(0, 1'b1, 1'b0, 1'b0);
        do_load(257, 1'b1, 1'b0, 1'b0);
        fill(1);
        do_load(1, 1'b1, 1'b0, 1'b0);

        tx_w.delete();
        tx_w.push_back(32'h0403_0201);
        do_load(1, 1'b1, 1'b0, 1'b0);
        do_load(1, 1'b1, 1'b0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill(n);
            do_load(n, 1'b1, 1'b0, $urandom_range(0, 3) == 0);
        end

        // Timeout: three data bytes, then silence
        got_a.delete();
        got_d.delete();
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        idle(15);
        check("to_before", error, 0);
        idle(1);
        check("to_error", error, 1);
        check("to_nostrobe", got_a.size(), 0);
        check("to_wl", words_loaded, 0);

        // Reset in the middle of a word
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        reset = 1'b1;
        #1;
        check("mr_cpu_reset", cpu_reset, 1);
        check("mr_busy", busy, 0);
        check("mr_le", load_enable, 0);
        check("mr_wl", words_loaded, 0);
        check("mr_error", error, 0);
        tick();
        reset = 1'b0;
        idle(2);
        check("mr_nostrobe", got_a.size(), 0);
        fill(1);
        do_load(1, 1'b1, 1'b0, 1'b0);

        // start during DATA is ignored
        fill(3);
        do_load(3, 1'b1, 1'b1, 1'b0);

        // start in RUN restarts a load from BASE
        pulse_start();
        check("rerun_cpu_reset", cpu_reset, 1);
        check("rerun_fetch", fetch_enable, 0);
        check("rerun_busy", busy, 1);
        fill(2);
        do_load(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
